fifo_sync_param: RTL
====================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 32, number of storage entries; SHALL be a power of two and >= 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, almost_full threshold; SHALL satisfy 1 <= AF_LEVEL <= DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 4, almost_empty threshold; SHALL satisfy 1 <= AE_LEVEL <= DEPTH-1.
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock for all logic, rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 rd_en  input  1  read request (FWFT=1: acknowledge of the presented word).
REQ-011 data_out  output  DATA_W  read data.
REQ-012 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 almost_full / almost_empty  output  1 each  occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-014 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow / underflow  output  1 each  single-cycle error pulses.

Function
REQ-016 Write accepted when wr_en=1 and full=0; the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 Read accepted when rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-018 Acceptance is evaluated against flag values at the clock edge; when full, a simultaneous read is accepted and the write is rejected; when empty, a simultaneous write is accepted and the read is rejected.
REQ-019 Simultaneous accepted write and read leave count unchanged; otherwise count changes by +1 (write) or -1 (read) in the same edge.
REQ-020 full, empty, almost_full and almost_empty are registered and SHALL reflect the count value they correspond to in the same cycle, with no extra cycle of lag.
REQ-021 FWFT=0: data_out updates to mem[rd_ptr] on the edge that accepts a read (visible the following cycle); otherwise it holds its value.
REQ-022 FWFT=1: whenever empty=0, data_out presents the oldest stored word; an accepted read advances to the next word in the following cycle; data_out is 0 while empty=1.
REQ-023 FWFT=1, write into an empty FIFO: the word appears on data_out, with empty deasserted, exactly one cycle after the write edge.
REQ-024 overflow is high for exactly one cycle following an edge where wr_en=1 and the write was rejected; underflow likewise for rd_en=1 with the read rejected.
REQ-025 Rejected accesses SHALL NOT modify memory, pointers or count.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order is strictly first-in first-out across wrap.

Reset
REQ-027 On rst=1 at a clock edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-028 Reset mid-operation discards all stored words; memory contents need not be cleared, and no stale word SHALL become visible afterwards.
REQ-029 rst has priority over wr_en and rd_en in the same cycle.

Structure
REQ-030 Shared package fifo_pkg holds the pointer/count width helper function and the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
REQ-031 Storage is one sub-module fifo_ram_2p: DATA_W x DEPTH, one synchronous write port and one read port, no reset on the array.
REQ-032 Illegal parameter combinations SHALL be flagged at elaboration.

Verification
REQ-033 Defaults, FWFT=0: 32 writes of 0x00..0x1F -> full=1 and count=32 after the 32nd edge; almost_full rises when count reaches 28; a 33rd write -> overflow pulse, count stays 32.
REQ-034 From full: 32 reads -> data_out sequence 0x00..0x1F, each value one cycle after its read; empty=1 after the last read; a further read -> underflow pulse, data_out holds 0x1F.
REQ-035 Half-full (16 words): wr_en=rd_en=1 for 40 cycles -> count constant at 16, pointers wrap, output order preserved.
REQ-036 FWFT=1, empty: write 0xA5 -> next cycle empty=0 and data_out=0xA5 with no read; rd_en=1 -> next cycle empty=1 and data_out=0.
REQ-037 Full FIFO with wr_en=rd_en=1 -> read accepted, write rejected, overflow pulse, count=31; then rst=1 with wr_en=1 -> all REQ-027 values, count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO read-mode constants and pointer width helper.
package fifo_pkg;
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: DATA_W x DEPTH storage, synchronous write port, asynchronous read port.
module fifo_ram_2p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered flags, occupancy count and
// selectable standard or first-word-fall-through read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = FIFO_STD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH):0]     count,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    if (DATA_W < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1 || AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1 ||
        (FWFT != FIFO_STD && FWFT != FIFO_FWFT)) begin : g_bad_param
        $error("fifo_sync_param: illegal parameter combination");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    // Flags are derived from next-state count so they never lag the count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= count_d == CW'(DEPTH);
            empty_q  <= count_d == '0;
            af_q     <= count_d >= CW'(AF_LEVEL);
            ae_q     <= count_d <= CW'(AE_LEVEL);
            ovf_q    <= wr_en && full_q;
            unf_q    <= rd_en && empty_q;
        end
    end

    fifo_ram_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign data_out = empty_q ? '0 : ram_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk)
            if (rst) data_q <= '0;
            else if (rd_acc) data_q <= ram_rdata;
        assign data_out = data_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule
